uart_tx_serializer: RTL and testbench
=====================================

Name: uart_tx_serializer

Overview:
Transmit half of the UART link. It takes the parallel result byte and send strobe from the RX/ALU interface FSM and serializes one frame onto the TX line: start bit, DATA_BITS data bits LSB-first, optional parity bit, stop bit. Bit timing comes from the shared baud-rate generator's oversampling tick; this block does not derive baud timing itself.

Parameters:
DATA_BITS, 8, data bits per frame
OVERSAMPLE, 16, i_tick pulses per start/data/parity bit
SB_TICKS, 16, i_tick pulses in the stop bit (16 = 1 stop bit, 32 = 2 stop bits)
PARITY_EN, 1, 1 = append parity bit, 0 = no parity bit
PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored if PARITY_EN=0)

Ports:
i_clock  in  1  system clock
i_reset  in  1  synchronous, active-high reset
i_tick  in  1  one-cycle baud oversample strobe from the baud generator
i_tx_start  in  1  request to send i_tx_data; sampled only in IDLE
i_tx_data  in  DATA_BITS  byte to transmit; captured when the request is accepted
o_tx  out  1  serial line, registered, idles high
o_tx_busy  out  1  high while a frame is in progress (START..STOP)
o_tx_done  out  1  one-cycle pulse when the stop bit completes

Behaviour:
- Reset: synchronous, active-high; reset i_reset, clock i_clock. On reset: o_tx=1, o_tx_busy=0, o_tx_done=0, state=IDLE, tick counter=0, bit index=0, shift register=0.
- Reset mid-frame: the frame is abandoned. o_tx=1 on the next cycle, no o_tx_done pulse.
- States (one-hot): IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - o_tx=1, busy=0.
  - i_tx_start=1 at cycle N captures i_tx_data into the shift register and captures the parity bit.
  - Parity bit = ^data for even parity, ~^data for odd parity.
  - Moves to START; o_tx=0 and busy=1 from cycle N+1 (latency 1 cycle).
- Tick counting:
  - The tick counter advances only on i_tick=1.
  - A bit ends on the cycle where i_tick=1 and counter==limit-1; the counter then clears.
  - limit is OVERSAMPLE for START/DATA/PARITY and SB_TICKS for STOP.
  - i_tick held high counts once per cycle.
- START: o_tx=0 for OVERSAMPLE ticks, then DATA with bit index=0.
- DATA:
  - o_tx = shift[0].
  - At each bit end: shift right by 1 and increment the bit index.
  - After bit DATA_BITS-1: go to PARITY if PARITY_EN, else STOP.
- PARITY: o_tx = captured parity bit for OVERSAMPLE ticks, then STOP.
- STOP: o_tx=1 for SB_TICKS ticks. At the final tick go to IDLE and assert o_tx_done for exactly the next cycle (the first IDLE cycle).
- Frame length in ticks: (1+DATA_BITS+PARITY_EN)*OVERSAMPLE + SB_TICKS. Default = 176 ticks.
- Busy handling:
  - i_tx_start while busy is ignored; no queuing.
  - i_tx_data changes while busy have no effect on the frame in progress.
- Back-to-back frames: i_tx_start in the o_tx_done cycle is accepted. o_tx is high for exactly one clock between frames.
- All outputs are registered; o_tx must never glitch.

Decomposition:
- Shared uart package holds:
  - state encodings (one-hot localparams IDLE/START/DATA/PARITY/STOP), shared with the receiver;
  - default DATA_BITS/OVERSAMPLE/SB_TICKS;
  - the parity-mode constants.
- No sub-module. The baud tick generator already exists and is instantiated at top level, feeding i_tick to both RX and TX.
- Parity is a single reduction expression inline.

Test Plan:
1. Reset: assert i_reset 3 cycles, i_tick toggling -> o_tx=1, o_tx_busy=0, o_tx_done=0 throughout; no activity on the line.
2. Even-parity frame: i_tick every 4 clocks, send 0x55 -> line sequence 0 | 1,0,1,0,1,0,1,0 | parity 0 | 1. Each bit is 16 ticks (64 clocks). o_tx_done pulses once, 176 ticks after start.
3. Odd-parity and no-parity frames:
   - PARITY_ODD=1, send 0x07 -> data 1,1,1,0,0,0,0,0, parity bit 0.
   - PARITY_EN=0, send 0x80 -> no parity bit; frame length 160 ticks.
4. Busy rejection: send 0xA3, then pulse i_tx_start with i_tx_data=0xFF mid-DATA -> transmitted bits remain 1,1,0,0,0,1,0,1; exactly one o_tx_done pulse.
5. Back-to-back frames: hold i_tx_start=1 with 0x3C during the o_tx_done cycle -> o_tx high for exactly 1 clock, then the next frame's start bit; second frame bits 0,0,1,1,1,1,0,0.
6. Reset mid-frame: reset during data bit 3 of 0x55 -> o_tx=1 and busy=0 the next cycle, no done pulse. A following 0x55 frame is transmitted bit-exact.

Source files
------------

// File: rtl/uart_tx_serializer_pkg.sv
// uart_tx_serializer_pkg: state encodings, frame defaults and parity modes shared by the UART halves
package uart_tx_serializer_pkg;
  typedef enum logic [4:0] {
    IDLE   = 5'b00001,
    START  = 5'b00010,
    DATA   = 5'b00100,
    PARITY = 5'b01000,
    STOP   = 5'b10000
  } uart_state_t;
  localparam int DEF_DATA_BITS  = 8;
  localparam int DEF_OVERSAMPLE = 16;
  localparam int DEF_SB_TICKS   = 16;
  localparam int PARITY_EVEN    = 0;
  localparam int PARITY_ODD_SEL = 1;
endpackage

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: serializes one start/data/parity/stop frame per accepted request, paced by i_tick
module uart_tx_serializer
  import uart_tx_serializer_pkg::*;
#(
  parameter int DATA_BITS  = DEF_DATA_BITS,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE,
  parameter int SB_TICKS   = DEF_SB_TICKS,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = PARITY_EVEN
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_tick,
  input  logic                 i_tx_start,
  input  logic [DATA_BITS-1:0] i_tx_data,
  output logic                 o_tx,
  output logic                 o_tx_busy,
  output logic                 o_tx_done
);
  localparam int TICK_MAX = OVERSAMPLE > SB_TICKS ? OVERSAMPLE : SB_TICKS;
  localparam int TW = $clog2(TICK_MAX) + 1;
  localparam int BW = $clog2(DATA_BITS) + 1;
  uart_state_t state_q, state_n;
  logic [TW-1:0] tick_q, tick_n;
  logic [BW-1:0] bit_q, bit_n;
  logic [DATA_BITS-1:0] shift_q, shift_n;
  logic par_q, par_n, tx_n, done_n, bit_end;
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q   <= IDLE;
      tick_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      o_tx      <= 1'b1;
      o_tx_busy <= 1'b0;
      o_tx_done <= 1'b0;
    end else begin
      state_q   <= state_n;
      tick_q    <= tick_n;
      bit_q     <= bit_n;
      shift_q   <= shift_n;
      par_q     <= par_n;
      o_tx      <= tx_n;
      o_tx_busy <= state_n != IDLE;
      o_tx_done <= done_n;
    end
  end
  always_comb begin
    state_n = state_q;
    tick_n  = tick_q;
    bit_n   = bit_q;
    shift_n = shift_q;
    par_n   = par_q;
    done_n  = 1'b0;
    bit_end = i_tick && tick_q == (state_q == STOP ? TW'(SB_TICKS - 1) : TW'(OVERSAMPLE - 1));
    if (state_q != IDLE && i_tick) tick_n = bit_end ? '0 : tick_q + 1'b1;
    case (state_q)
      IDLE: if (i_tx_start) begin
        state_n = START;
        shift_n = i_tx_data;
        par_n   = (^i_tx_data) ^ PARITY_ODD[0];
        tick_n  = '0;
        bit_n   = '0;
      end
      START: if (bit_end) begin
        state_n = DATA;
        bit_n   = '0;
      end
      DATA: if (bit_end) begin
        shift_n = shift_q >> 1;
        bit_n   = bit_q + 1'b1;
        if (bit_q == BW'(DATA_BITS - 1)) state_n = PARITY_EN != 0 ? PARITY : STOP;
      end
      PARITY: if (bit_end) state_n = STOP;
      STOP: if (bit_end) begin
        state_n = IDLE;
        done_n  = 1'b1;
      end
      default: state_n = IDLE;
    endcase
    // Line level is registered from the next state so o_tx changes cleanly on the clock edge.
    tx_n = state_n == START ? 1'b0 : state_n == DATA ? shift_n[0] : state_n == PARITY ? par_n : 1'b1;
  end
endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: three parity variants checked cycle by cycle against a tick-counting frame model
module tb_uart_tx_serializer;
  localparam logic [2:0] PE = 3'b011;
  localparam logic [2:0] PO = 3'b010;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick = 1'b0;
  logic [2:0] start = '0;
  logic [7:0] data [3];
  wire [2:0] tx, busy, done;
  int mode = 0;
  int tc = 0;
  int tk_total = 0;
  int n_checks = 0;
  int n_fail = 0;
  logic act [3];
  int ts [3];
  logic [7:0] dat [3];
  logic mdone [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    uart_tx_serializer #(.PARITY_EN(PE[g] ? 1 : 0), .PARITY_ODD(PO[g] ? 1 : 0)) dut (
      .i_clock(clk), .i_reset(rst), .i_tick(tick), .i_tx_start(start[g]), .i_tx_data(data[g]),
      .o_tx(tx[g]), .o_tx_busy(busy[g]), .o_tx_done(done[g]));
  end

  initial forever begin
    @(posedge clk);
    #1;
    tc++;
    tick = mode == 0 ? (tc % 4 == 0) : mode == 1 ? ($urandom_range(0, 2) == 0) : 1'b1;
  end

  always @(posedge clk) if (tick) tk_total <= tk_total + 1;

  function automatic int flen(int i);
    return (9 + int'(PE[i])) * 16 + 16;
  endfunction

  function automatic logic bitval(int i, int t);
    int seg = t / 16;
    if (seg == 0) return 1'b0;
    if (seg <= 8) return dat[i][seg-1];
    if (PE[i] && seg == 9) return logic'($countones(dat[i]) % 2) ^ PO[i];
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        act[i] <= 1'b0;
        mdone[i] <= 1'b0;
        ts[i] <= 0;
      end else begin
        mdone[i] <= 1'b0;
        if (!act[i]) begin
          if (start[i]) begin
            act[i] <= 1'b1;
            ts[i] <= 0;
            dat[i] <= data[i];
          end
        end else if (tick) begin
          ts[i] <= ts[i] + 1;
          if (ts[i] + 1 == flen(i)) begin
            act[i] <= 1'b0;
            mdone[i] <= 1'b1;
          end
        end
      end
    end
  end

  task automatic test_reset;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      start = 3'b111;
      mode = 2 - c % 2 * 2;
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if ({tx[i], busy[i], done[i]} !== 3'b100) begin
          n_fail++;
          $display("FAIL reset line%0d: tx/busy/done=%b%b%b expected 100", i, tx[i], busy[i], done[i]);
        end
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    start = '0;
    mode = 0;
  endtask

  task automatic test_frames;
    int pulses [3] = '{0, 0, 0};
    int len [3] = '{0, 0, 0};
    int base;
    logic [2:0] e;
    @(posedge clk);
    #1;
    data = '{8'h55, 8'h07, 8'h80};
    start = 3'b111;
    @(posedge clk);
    #1;
    start = '0;
    base = tk_total;
    for (int c = 0; c < 760; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        e = {act[i] ? bitval(i, ts[i]) : 1'b1, act[i], mdone[i]};
        n_checks++;
        if ({tx[i], busy[i], done[i]} !== e) begin
          n_fail++;
          if (n_fail < 20) $display("FAIL frames line%0d @%0t: tx/busy/done=%b%b%b expected %b", i, $time, tx[i], busy[i], done[i], e);
        end
        if (done[i]) begin
          pulses[i]++;
          len[i] = tk_total - base;
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      n_checks += 2;
      if (pulses[i] != 1) begin
        n_fail++;
        $display("FAIL frames done_count line%0d: got %0d expected 1", i, pulses[i]);
      end
      if (len[i] != (i == 2 ? 160 : 176)) begin
        n_fail++;
        $display("FAIL frames length line%0d: got %0d ticks expected %0d", i, len[i], i == 2 ? 160 : 176);
      end
    end
  endtask

  task automatic test_busy;
    int pulses = 0;
    logic [2:0] e;
    @(posedge clk);
    #1;
    data[0] = 8'hA3;
    start = 3'b001;
    @(posedge clk);
    #1;
    start = '0;
    for (int c = 0; c < 760; c++) begin
      @(negedge clk);
      e = {act[0] ? bitval(0, ts[0]) : 1'b1, act[0], mdone[0]};
      n_checks++;
      if ({tx[0], busy[0], done[0]} !== e) begin
        n_fail++;
        if (n_fail < 20) $display("FAIL busy @%0t: tx/busy/done=%b%b%b expected %b", $time, tx[0], busy[0], done[0], e);
      end
      if (done[0]) pulses++;
      if (c == 200) begin
        start[0] = 1'b1;
        data[0] = 8'hFF;
      end
      if (c == 201) start[0] = 1'b0;
    end
    n_checks++;
    if (pulses != 1) begin
      n_fail++;
      $display("FAIL busy done_count: got %0d expected 1", pulses);
    end
  endtask

  task automatic test_back_to_back;
    int pulses = 0;
    int gap = 0;
    logic sent = 1'b0;
    logic rebusy = 1'b0;
    logic [2:0] e;
    @(posedge clk);
    #1;
    data[0] = 8'hC5;
    start = 3'b001;
    @(posedge clk);
    #1;
    start = '0;
    for (int c = 0; c < 1600 && pulses < 2; c++) begin
      @(negedge clk);
      e = {act[0] ? bitval(0, ts[0]) : 1'b1, act[0], mdone[0]};
      n_checks++;
      if ({tx[0], busy[0], done[0]} !== e) begin
        n_fail++;
        if (n_fail < 20) $display("FAIL b2b @%0t: tx/busy/done=%b%b%b expected %b", $time, tx[0], busy[0], done[0], e);
      end
      if (done[0]) pulses++;
      if (pulses >= 1 && busy[0]) rebusy = 1'b1;
      if (pulses >= 1 && !busy[0] && !rebusy) gap++;
      start[0] = 1'b0;
      if (mdone[0] && !sent) begin
        start[0] = 1'b1;
        data[0] = 8'h3C;
        sent = 1'b1;
      end
    end
    n_checks += 2;
    if (gap != 1) begin
      n_fail++;
      $display("FAIL b2b idle_gap: got %0d clocks expected 1", gap);
    end
    if (pulses != 2) begin
      n_fail++;
      $display("FAIL b2b done_count: got %0d expected 2", pulses);
    end
  endtask

  task automatic test_reset_mid;
    int base;
    int pulses = 0;
    int len = 0;
    logic [2:0] e;
    @(posedge clk);
    #1;
    data[0] = 8'h55;
    start = 3'b001;
    @(posedge clk);
    #1;
    start = '0;
    base = tk_total;
    for (int c = 0; c < 1000 && tk_total - base != 72; c++) @(negedge clk);
    n_checks++;
    if (tk_total - base != 72) begin
      n_fail++;
      $display("FAIL reset_mid reach_bit3: got %0d ticks expected 72", tk_total - base);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if ({tx[0], busy[0], done[0]} !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_mid abandon: tx/busy/done=%b%b%b expected 100", tx[0], busy[0], done[0]);
    end
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      n_checks++;
      if ({tx[0], busy[0], done[0]} !== 3'b100) begin
        n_fail++;
        if (n_fail < 20) $display("FAIL reset_mid idle @%0t: tx/busy/done=%b%b%b expected 100", $time, tx[0], busy[0], done[0]);
      end
    end
    @(posedge clk);
    #1;
    start = 3'b001;
    @(posedge clk);
    #1;
    start = '0;
    base = tk_total;
    for (int c = 0; c < 760; c++) begin
      @(negedge clk);
      e = {act[0] ? bitval(0, ts[0]) : 1'b1, act[0], mdone[0]};
      n_checks++;
      if ({tx[0], busy[0], done[0]} !== e) begin
        n_fail++;
        if (n_fail < 20) $display("FAIL reset_mid refresh @%0t: tx/busy/done=%b%b%b expected %b", $time, tx[0], busy[0], done[0], e);
      end
      if (done[0]) begin
        pulses++;
        len = tk_total - base;
      end
    end
    n_checks++;
    if (pulses != 1 || len != 176) begin
      n_fail++;
      $display("FAIL reset_mid refresh_done: got %0d pulses at %0d ticks expected 1 at 176", pulses, len);
    end
  endtask

  task automatic test_random;
    logic [2:0] e;
    for (int r = 0; r < 6; r++) begin
      int pulses [3] = '{0, 0, 0};
      @(posedge clk);
      #1;
      mode = r % 3;
      for (int i = 0; i < 3; i++) data[i] = 8'($urandom);
      start = 3'b111;
      @(posedge clk);
      #1;
      start = '0;
      for (int c = 0; c < 4000 && (pulses[0] == 0 || pulses[1] == 0 || pulses[2] == 0); c++) begin
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
          e = {act[i] ? bitval(i, ts[i]) : 1'b1, act[i], mdone[i]};
          n_checks++;
          if ({tx[i], busy[i], done[i]} !== e) begin
            n_fail++;
            if (n_fail < 20) $display("FAIL random line%0d @%0t: tx/busy/done=%b%b%b expected %b", i, $time, tx[i], busy[i], done[i], e);
          end
          if (done[i]) pulses[i]++;
          data[i] = 8'($urandom);
        end
      end
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (pulses[i] != 1) begin
          n_fail++;
          $display("FAIL random done_count line%0d round %0d: got %0d expected 1", i, r, pulses[i]);
        end
      end
    end
    mode = 0;
  endtask

  initial begin
    data = '{8'h00, 8'h00, 8'h00};
    test_reset;
    test_frames;
    test_busy;
    test_back_to_back;
    test_reset_mid;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
